// File: rtl/fm_tuning_word_gen.sv
// FM tuning word generator: carrier +/- (deviation * |sample|) >> (MW-1), with saturation.
// Iterative shift-add multiply, one sample bit per clock.
module fm_tuning_word_gen #(
  parameter int unsigned DW = 48,
  parameter int unsigned MW = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [DW-1:0] Carrier,
  input  logic [DW-1:0] Deviation,
  input  logic [MW-1:0] Mod_Sample,
  input  logic          Mod_Valid,
  input  logic          FM_EN,
  output logic [DW-1:0] FTW_Out,
  output logic          FTW_Valid,
  output logic          Busy,
  output logic          Overrun
);

  localparam int unsigned AW = DW + MW;
  localparam int unsigned CW = $clog2(MW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] ADD  = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] carrier;
  logic [DW-1:0] deviation;
  logic [MW-1:0] magnitude;
  logic          sign;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  logic [MW-1:0] sample_mag;
  logic [AW-1:0] partial;
  logic [DW:0]   scaled;
  logic [DW+1:0] sum;
  logic          borrow;
  logic [DW-1:0] ftw_next;

  // Two's complement negate; the most negative sample maps to 2^(MW-1) exactly.
  assign sample_mag = Mod_Sample[MW-1] ? (~Mod_Sample + MW'(1)) : Mod_Sample;
  assign partial    = {{MW{1'b0}}, deviation} << cnt;
  assign scaled     = acc[AW-1:MW-1];
  assign sum        = {1'b0, {1'b0, carrier}} + {1'b0, scaled};
  assign borrow     = scaled > {1'b0, carrier};
  assign Busy       = (state != IDLE);

  always_comb begin
    ftw_next = '0;
    if (sign) begin
      ftw_next = borrow ? '0 : (carrier - scaled[DW-1:0]);
    end else begin
      ftw_next = (sum[DW+1:DW] != 2'b00) ? '1 : sum[DW-1:0];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= IDLE;
      carrier   <= '0;
      deviation <= '0;
      magnitude <= '0;
      sign      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      FTW_Out   <= '0;
      FTW_Valid <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      FTW_Valid <= 1'b0;
      if (Mod_Valid && (state != IDLE)) begin
        Overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (Mod_Valid) begin
            carrier   <= Carrier;
            deviation <= Deviation;
            magnitude <= sample_mag;
            sign      <= Mod_Sample[MW-1];
            acc       <= '0;
            cnt       <= '0;
            // Bypass skips MUL; the zero accumulator makes the result equal Carrier.
            state     <= FM_EN ? MUL : ADD;
          end
        end
        MUL: begin
          if (magnitude[cnt]) begin
            acc <= acc + partial;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(MW - 1)) begin
            state <= ADD;
          end
        end
        ADD: begin
          FTW_Out   <= ftw_next;
          FTW_Valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_tuning_word_gen.sv
// Directed self-checking bench for fm_tuning_word_gen.
module tb_fm_tuning_word_gen;

  localparam int unsigned DW = 48;
  localparam int unsigned MW = 16;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [DW-1:0] Carrier;
  logic [DW-1:0] Deviation;
  logic [MW-1:0] Mod_Sample;
  logic          Mod_Valid;
  logic          FM_EN;
  logic [DW-1:0] FTW_Out;
  logic          FTW_Valid;
  logic          Busy;
  logic          Overrun;

  int checks   = 0;
  int failures = 0;
  int pulses;

  fm_tuning_word_gen #(.DW(DW), .MW(MW)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Carrier    (Carrier),
    .Deviation  (Deviation),
    .Mod_Sample (Mod_Sample),
    .Mod_Valid  (Mod_Valid),
    .FM_EN      (FM_EN),
    .FTW_Out    (FTW_Out),
    .FTW_Valid  (FTW_Valid),
    .Busy       (Busy),
    .Overrun    (Overrun)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ftw"}, 64'(FTW_Out), 64'h0);
    chk({tag, "_valid"}, 64'(FTW_Valid), 64'h0);
    chk({tag, "_busy"}, 64'(Busy), 64'h0);
    chk({tag, "_overrun"}, 64'(Overrun), 64'h0);
  endtask

  // Full FM transaction; inputs are scrambled after accept to show they were latched.
  task automatic run_fm(input string tag, input logic [DW-1:0] car, input logic [DW-1:0] dev,
                        input logic [MW-1:0] smp, input logic [DW-1:0] exp);
    Carrier = car; Deviation = dev; Mod_Sample = smp; FM_EN = 1'b1; Mod_Valid = 1'b1;
    tick();
    Mod_Valid = 1'b0; Carrier = ~car; Deviation = ~dev; Mod_Sample = ~smp; FM_EN = 1'b0;
    chk({tag, "_busy_e0"}, 64'(Busy), 64'h1);
    repeat (16) tick();
    chk({tag, "_novalid_e16"}, 64'(FTW_Valid), 64'h0);
    tick();
    chk({tag, "_ftw"}, 64'(FTW_Out), 64'(exp));
    chk({tag, "_valid"}, 64'(FTW_Valid), 64'h1);
    chk({tag, "_idle"}, 64'(Busy), 64'h0);
  endtask

  initial begin
    Reset = 1'b0; Carrier = '0; Deviation = '0; Mod_Sample = '0; Mod_Valid = 1'b0; FM_EN = 1'b0;
    tick(); tick();
    check_reset_state("reset");
    Reset = 1'b1;
    tick();

    // Bypass: one-clock latency, output equals carrier.
    Carrier = 48'h0000_1000_0000; Deviation = 48'h0000_0010_0000; Mod_Sample = 16'h4000;
    FM_EN = 1'b0; Mod_Valid = 1'b1;
    tick();
    Mod_Valid = 1'b0; Carrier = '0;
    chk("byp_busy", 64'(Busy), 64'h1);
    chk("byp_early_valid", 64'(FTW_Valid), 64'h0);
    tick();
    chk("byp_ftw", 64'(FTW_Out), 64'h0000_1000_0000);
    chk("byp_valid", 64'(FTW_Valid), 64'h1);
    chk("byp_idle", 64'(Busy), 64'h0);
    tick();
    chk("byp_single_pulse", 64'(FTW_Valid), 64'h0);
    chk("byp_hold", 64'(FTW_Out), 64'h0000_1000_0000);

    run_fm("pos_half", 48'h0000_1000_0000, 48'h0000_0010_0000, 16'h4000, 48'h0000_1008_0000);
    run_fm("neg_full", 48'h0000_1000_0000, 48'h0000_0010_0000, 16'h8000, 48'h0000_0FF0_0000);
    run_fm("sat_high", 48'hFFFF_FFFF_F000, 48'h0000_0001_0000, 16'h7FFF, 48'hFFFF_FFFF_FFFF);
    run_fm("sat_low", 48'h0000_0000_0100, 48'h0000_0001_0000, 16'h8000, 48'h0000_0000_0000);
    run_fm("sym_pos", 48'h0000_0000_1000, 48'h0000_0000_0003, 16'h0001, 48'h0000_0000_1000);
    run_fm("sym_neg", 48'h0000_0000_1000, 48'h0000_0000_0003, 16'hFFFF, 48'h0000_0000_1000);
    // 0x7FFF * 0x7FFF >> 15 = 0x7FFE; 0x20000 - 0x7FFE = 0x18002
    run_fm("neg_odd", 48'h0000_0002_0000, 48'h0000_0000_7FFF, 16'h8001, 48'h0000_0001_8002);

    // Reset mid-MUL discards the operation.
    Carrier = 48'h0000_1000_0000; Deviation = 48'h0000_0010_0000; Mod_Sample = 16'h4000;
    FM_EN = 1'b1; Mod_Valid = 1'b1;
    tick();
    Mod_Valid = 1'b0;
    repeat (5) tick();
    Reset = 1'b0;
    tick(); tick();
    check_reset_state("midmul_reset");
    Reset = 1'b1;
    pulses = 0;
    repeat (25) begin
      tick();
      if (FTW_Valid) pulses++;
    end
    chk("midmul_no_pulse", 64'(pulses), 64'h0);
    chk("midmul_ftw_hold", 64'(FTW_Out), 64'h0);

    // Mod_Valid coinciding with the output edge is dropped and flagged.
    Mod_Sample = 16'h4000; FM_EN = 1'b1; Mod_Valid = 1'b1;
    tick();
    Mod_Valid = 1'b0;
    repeat (16) tick();
    Mod_Sample = 16'h8000; Mod_Valid = 1'b1;
    tick();
    Mod_Valid = 1'b0;
    chk("e17_ftw", 64'(FTW_Out), 64'h0000_1008_0000);
    chk("e17_overrun", 64'(Overrun), 64'h1);
    chk("e17_dropped", 64'(Busy), 64'h0);

    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("clear_overrun", 64'(Overrun), 64'h0);

    // Second strobe five clocks in is an overrun; result reflects the first sample.
    Mod_Sample = 16'h4000; Mod_Valid = 1'b1;
    tick();
    Mod_Valid = 1'b0;
    repeat (4) tick();
    Mod_Sample = 16'h8000; Mod_Valid = 1'b1;
    tick();
    Mod_Valid = 1'b0;
    chk("ovr_set", 64'(Overrun), 64'h1);
    repeat (11) tick();
    chk("ovr_pre_valid", 64'(FTW_Valid), 64'h0);
    tick();
    chk("ovr_ftw", 64'(FTW_Out), 64'h0000_1008_0000);
    chk("ovr_valid", 64'(FTW_Valid), 64'h1);

    // Back-to-back: strobe in the FTW_Valid cycle is accepted.
    Mod_Sample = 16'h8000; Mod_Valid = 1'b1;
    tick();
    Mod_Valid = 1'b0;
    chk("b2b_busy", 64'(Busy), 64'h1);
    repeat (16) tick();
    chk("b2b_pre_valid", 64'(FTW_Valid), 64'h0);
    tick();
    chk("b2b_ftw", 64'(FTW_Out), 64'h0000_0FF0_0000);
    chk("b2b_valid", 64'(FTW_Valid), 64'h1);
    chk("ovr_sticky", 64'(Overrun), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm_tuning_word_gen.md
# fm_tuning_word_gen

Computes the instantaneous DDS frequency tuning word for FM output by combining the carrier tuning word with the deviation value held in the FM deviation register and a signed modulating sample. It sits directly downstream of the deviation register and upstream of the carrier phase accumulator. A new word is produced per accepted sample. The multiply is iterative, one shift-add per clock, to keep area low.

## Interface
- `DW`, default 48: width of the tuning words and the deviation value.
- `MW`, default 16: width of the signed modulating sample.
- `Clock`, input, 1: system clock, rising edge.
- `Reset`, input, 1: synchronous, active-low reset.
- `Carrier`, input, DW: carrier tuning word, unsigned. Sampled on accept.
- `Deviation`, input, DW: peak deviation tuning word, unsigned, from the deviation register. Sampled on accept.
- `Mod_Sample`, input, MW: modulating sample, two's complement. Full scale is ±1.0. Sampled on accept.
- `Mod_Valid`, input, 1: sample strobe, one cycle.
- `FM_EN`, input, 1: 1 selects the FM computation, 0 selects bypass. Sampled on accept.
- `FTW_Out`, output, DW: registered tuning word.
- `FTW_Valid`, output, 1: one-cycle pulse when `FTW_Out` updates.
- `Busy`, output, 1: high whenever the state is not IDLE.
- `Overrun`, output, 1: sticky flag, set when `Mod_Valid` arrives while `Busy`.

## Operation
- Clock is `Clock`; reset is synchronous and active-low on `Reset`.
- Reset (`Reset`=0 at an edge) has priority over all other activity:
  - State goes to IDLE and any in-flight operation is discarded.
  - `FTW_Out`=0, `FTW_Valid`=0, `Busy`=0, `Overrun`=0.
- States:
  - **IDLE:** on `Mod_Valid`=1, latch `Carrier`, `Deviation`, `Mod_Sample` and `FM_EN`. Go to MUL if `FM_EN`=1, otherwise to ADD with the product forced to 0 (bypass).
  - **MUL:** 16 cycles (MW). Each cycle adds `Deviation` shifted left by the bit index into a 64-bit (DW+MW) accumulator when the corresponding bit of the sample magnitude is set. A 4-bit counter runs 0..15; the state leaves to ADD when the counter reaches 15.
  - **ADD:** compute the output, register it into `FTW_Out`, assert `FTW_Valid` for one cycle, return to IDLE.
- Arithmetic:
  - Sign is the MSB of `Mod_Sample`.
  - Magnitude is the 16-bit unsigned absolute value; 0x8000 gives magnitude 32768 exactly.
  - scaled = (Deviation × magnitude) >> 15, truncated toward zero. This is sign-symmetric.
  - Sign 0: FTW = Carrier + scaled, computed DW+1 bits wide. On carry-out, saturate to all ones (0xFFFF_FFFF_FFFF).
  - Sign 1: FTW = Carrier − scaled. On borrow, saturate to 0.
  - Wrap-around is never allowed.
- `Mod_Valid` while `Busy`=1: the sample is dropped, `Overrun` is set, and the operation in flight is unaffected.
- Input changes on `Carrier`, `Deviation` and `FM_EN` after accept do not affect the operation in flight.
- `FTW_Out` holds its value between updates.

## Timing
- Let edge E0 be the edge that samples `Mod_Valid`=1 in IDLE.
- FM path:
  - MUL iterations occur at E1..E16; ADD occurs at E17.
  - `FTW_Out` and `FTW_Valid`=1 are visible after E17.
  - Latency is 17 clocks.
- Bypass path: the output is written at E1, giving `FTW_Out`=Carrier with `FTW_Valid` high after E1. Latency is 1 clock.
- `Busy` is registered:
  - High after E0.
  - Low after E17 on the FM path, or after E1 on bypass.
- A new `Mod_Valid` is accepted at the edge following the output edge, i.e. in the cycle `FTW_Valid` is high. Maximum FM throughput is 1 sample per 18 clocks.
- A `Mod_Valid` at the output edge itself (E17) is an overrun.
- Reset asserted at any edge between E1 and E17: no `FTW_Valid` pulse occurs, and outputs hold their reset values until the next accept completes.

## Test plan
- **Reset:** hold `Reset`=0 for 2 clocks mid-MUL → `FTW_Out`=0, `FTW_Valid`=0, `Busy`=0, `Overrun`=0, and no later pulse for the discarded sample.
- **Bypass:** `FM_EN`=0, `Carrier`=0x0000_1000_0000, `Mod_Valid` pulse → after 1 clock `FTW_Out`=0x0000_1000_0000 with a single `FTW_Valid` pulse.
- **Positive half-scale:** `Carrier`=0x0000_1000_0000, `Deviation`=0x0000_0010_0000, `Mod_Sample`=0x4000 → after 17 clocks `FTW_Out`=0x0000_1008_0000. Negative full-scale 0x8000 → 0x0000_0FF0_0000.
- **Saturation:**
  - `Carrier`=0xFFFF_FFFF_F000, `Deviation`=0x10000, sample 0x7FFF → 0xFFFF_FFFF_FFFF.
  - `Carrier`=0x100, `Deviation`=0x10000, sample 0x8000 → 0x0000_0000_0000.
- **Overrun/back-to-back:**
  - A second `Mod_Valid` 5 clocks after the first → result equals the first sample only, `Overrun`=1 and it stays 1.
  - A `Mod_Valid` in the `FTW_Valid` cycle → accepted, with its result 17 clocks later.
- **Sign symmetry:** `Deviation`=0x3, samples 0x0001 and 0xFFFF with `Carrier`=0x1000 → both results equal 0x1000, since truncation is toward zero.
